// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA timing controller.
//   - default 640x480 @ 60 Hz horizontal/vertical timing (pixels / lines)
//   - derived totals H_TOTAL / V_TOTAL
//   - counter and prescaler widths
//   - rgb_t colour bundle and a half-open range helper for region decode
package vga_pkg;

   localparam int CNT_W = 10;
   localparam int DIV_W = 4;

   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;

   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   // True when lo <= cnt < lo + len (unsigned).
   function automatic logic in_range(input logic [CNT_W-1:0] cnt,
                                     input int lo,
                                     input int len);
      logic [CNT_W-1:0] lo_c;
      logic [CNT_W-1:0] hi_c;
      lo_c = CNT_W'(lo);
      hi_c = CNT_W'(lo + len);
      return (cnt >= lo_c) && (cnt < hi_c);
   endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel prescaler plus horizontal/vertical scan counters and
// region decode.
// Ports:
//   clk       in   system clock, rising edge
//   aresetn   in   synchronous reset, asserted when 1
//   div_cnt   out  prescaler count, 0..PIX_DIV-1
//   pix_tick  out  one-cycle strobe on the last clk of each pixel
//   h_cnt     out  horizontal pixel counter, 0..H_TOTAL-1
//   v_cnt     out  vertical line counter, 0..V_TOTAL-1
//   visible   out  h_cnt/v_cnt inside the active picture
//   hsync_on  out  h_cnt inside the horizontal sync pulse
//   vsync_on  out  v_cnt inside the vertical sync pulse
module vga_timing
   import vga_pkg::*;
#(
   parameter int PIX_DIV   = 2,
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int H_FRONT   = H_FRONT_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BACK    = H_BACK_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int V_FRONT   = V_FRONT_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BACK    = V_BACK_DEF
) (
   input  logic             clk,
   input  logic             aresetn,
   output logic [DIV_W-1:0] div_cnt,
   output logic             pix_tick,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             visible,
   output logic             hsync_on,
   output logic             vsync_on
);

   localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
   localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VISIBLE);

   logic [DIV_W-1:0] div_cnt_d, div_cnt_q;
   logic [CNT_W-1:0] h_cnt_d, h_cnt_q;
   logic [CNT_W-1:0] v_cnt_d, v_cnt_q;
   logic             tick;

   always_comb begin
      div_cnt_d = div_cnt_q + 1'b1;
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      tick      = (div_cnt_q == DIV_LAST);
      if (tick) begin
         div_cnt_d = '0;
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            // Line advance happens on the same tick that ends the line.
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (aresetn) begin
         div_cnt_q <= '0;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
      end
   end

   assign div_cnt  = div_cnt_q;
   assign pix_tick = tick;
   assign h_cnt    = h_cnt_q;
   assign v_cnt    = v_cnt_q;
   assign visible  = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
   assign hsync_on = in_range(h_cnt_q, H_VISIBLE + H_FRONT, H_SYNC);
   assign vsync_on = in_range(v_cnt_q, V_VISIBLE + V_FRONT, V_SYNC);

endmodule

// File: rtl/vga_controller.sv
// vga_controller: 640x480 @ 60 Hz VGA timing generator with a registered
// RGB444 output stage. Colour is forwarded only in the visible region and
// forced to black elsewhere; sync levels follow SYNC_ACTIVE.
// Ports:
//   clk                  in   system clock, rising edge
//   aresetn              in   synchronous reset, asserted when 1
//   red_in/green_in/blue_in     in   4-bit pixel colour from the source
//   red_out/green_out/blue_out  out  registered colour to the DAC
//   horizontal_sync_out  out  registered HSYNC
//   vertical_sync_out    out  registered VSYNC
module vga_controller
   import vga_pkg::*;
#(
   parameter int   PIX_DIV     = 2,
   parameter int   H_VISIBLE   = H_VISIBLE_DEF,
   parameter int   H_FRONT     = H_FRONT_DEF,
   parameter int   H_SYNC      = H_SYNC_DEF,
   parameter int   H_BACK      = H_BACK_DEF,
   parameter int   V_VISIBLE   = V_VISIBLE_DEF,
   parameter int   V_FRONT     = V_FRONT_DEF,
   parameter int   V_SYNC      = V_SYNC_DEF,
   parameter int   V_BACK      = V_BACK_DEF,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic       clk,
   input  logic       aresetn,
   input  logic [3:0] red_in,
   input  logic [3:0] green_in,
   input  logic [3:0] blue_in,
   output logic [3:0] red_out,
   output logic [3:0] green_out,
   output logic [3:0] blue_out,
   output logic       horizontal_sync_out,
   output logic       vertical_sync_out
);

   logic [DIV_W-1:0] div_cnt;
   logic             pix_tick;
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             visible;
   logic             hsync_on;
   logic             vsync_on;

   vga_timing #(
      .PIX_DIV   (PIX_DIV),
      .H_VISIBLE (H_VISIBLE),
      .H_FRONT   (H_FRONT),
      .H_SYNC    (H_SYNC),
      .H_BACK    (H_BACK),
      .V_VISIBLE (V_VISIBLE),
      .V_FRONT   (V_FRONT),
      .V_SYNC    (V_SYNC),
      .V_BACK    (V_BACK)
   ) u_timing (
      .clk      (clk),
      .aresetn  (aresetn),
      .div_cnt  (div_cnt),
      .pix_tick (pix_tick),
      .h_cnt    (h_cnt),
      .v_cnt    (v_cnt),
      .visible  (visible),
      .hsync_on (hsync_on),
      .vsync_on (vsync_on)
   );

   // Raw counters are only needed for debug taps; only the decoded flags
   // drive the output stage.
   logic unused_timing;
   assign unused_timing = ^{div_cnt, pix_tick, h_cnt, v_cnt};

   rgb_t rgb_d, rgb_q;
   logic hsync_d, hsync_q;
   logic vsync_d, vsync_q;

   always_comb begin
      rgb_d   = '0;
      hsync_d = hsync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d = vsync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      if (visible) begin
         rgb_d.r = red_in;
         rgb_d.g = green_in;
         rgb_d.b = blue_in;
      end
   end

   always_ff @(posedge clk) begin
      if (aresetn) begin
         rgb_q   <= '0;
         hsync_q <= ~SYNC_ACTIVE;
         vsync_q <= ~SYNC_ACTIVE;
      end else begin
         rgb_q   <= rgb_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign red_out             = rgb_q.r;
   assign green_out           = rgb_q.g;
   assign blue_out            = rgb_q.b;
   assign horizontal_sync_out = hsync_q;
   assign vertical_sync_out   = vsync_q;

endmodule

// File: tb/tb_vga_controller.sv
// tb_vga_controller: directed bench for vga_controller. Horizontal timing
// and pixel divider are the 640x480 defaults; the frame is shortened to
// 15 lines (8 visible, 2 front, 2 sync, 3 back) so whole frames fit in a
// short run. cyc numbers the clk edges since the last reset release
// (edge 1 is the first edge with aresetn == 0).
module tb_vga_controller;

   localparam int PIX_DIV = 2;
   localparam int V_VIS   = 8;
   localparam int V_FP    = 2;
   localparam int V_SY    = 2;
   localparam int V_BP    = 3;

   logic       clk = 1'b0;
   logic       aresetn;
   logic [3:0] red_in, green_in, blue_in;
   logic [3:0] red_out, green_out, blue_out;
   logic       horizontal_sync_out, vertical_sync_out;

   always #5 clk = ~clk;

   vga_controller #(
      .PIX_DIV   (PIX_DIV),
      .V_VISIBLE (V_VIS),
      .V_FRONT   (V_FP),
      .V_SYNC    (V_SY),
      .V_BACK    (V_BP)
   ) dut (
      .clk                 (clk),
      .aresetn             (aresetn),
      .red_in              (red_in),
      .green_in            (green_in),
      .blue_in             (blue_in),
      .red_out             (red_out),
      .green_out           (green_out),
      .blue_out            (blue_out),
      .horizontal_sync_out (horizontal_sync_out),
      .vertical_sync_out   (vertical_sync_out)
   );

   int cyc       = 0;
   int n_vec     = 0;
   int n_err     = 0;
   int blank_lo  = 12801;
   int blank_hi  = 24000;
   int blank_bad = 0;

   function automatic logic [11:0] col();
      return {red_out, green_out, blue_out};
   endfunction

   function automatic logic [13:0] obs();
      return {red_out, green_out, blue_out, horizontal_sync_out, vertical_sync_out};
   endfunction

   function automatic logic [13:0] ev(input logic [11:0] c, input logic hs, input logic vs);
      return {c, hs, vs};
   endfunction

   task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= blank_lo && cyc <= blank_hi && col() != 12'h000)
         blank_bad++;
   endtask

   task automatic at(input int target, input string tag, input logic [13:0] exp);
      while (cyc < target) tick();
      chk(tag, obs(), exp);
   endtask

   task automatic set_rgb(input logic [11:0] c);
      {red_in, green_in, blue_in} = c;
   endtask

   // Timing checks common to the first frame and the frame after a reset.
   task automatic line_checks(input string pfx);
      at(1280,  {pfx, "_h639"},      ev(12'hFFF, 1'b1, 1'b1));
      at(1281,  {pfx, "_h640_blank"}, ev(12'h000, 1'b1, 1'b1));
      at(1312,  {pfx, "_hs_pre"},    ev(12'h000, 1'b1, 1'b1));
      at(1313,  {pfx, "_hs_fall"},   ev(12'h000, 1'b0, 1'b1));
      at(1504,  {pfx, "_hs_last"},   ev(12'h000, 1'b0, 1'b1));
      at(1505,  {pfx, "_hs_rise"},   ev(12'h000, 1'b1, 1'b1));
      at(1600,  {pfx, "_h799"},      ev(12'h000, 1'b1, 1'b1));
      at(1601,  {pfx, "_line1_h0"},  ev(12'hFFF, 1'b1, 1'b1));
   endtask

   task automatic vsync_checks(input string pfx);
      at(16000, {pfx, "_vs_pre"},  ev(12'h000, 1'b1, 1'b1));
      at(16001, {pfx, "_vs_fall"}, ev(12'h000, 1'b1, 1'b0));
      at(19200, {pfx, "_vs_last"}, ev(12'h000, 1'b1, 1'b0));
      at(19201, {pfx, "_vs_rise"}, ev(12'h000, 1'b1, 1'b1));
   endtask

   initial begin
      aresetn = 1'b1;
      set_rgb(12'hFFF);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rst_hold", obs(), ev(12'h000, 1'b1, 1'b1));
      end

      aresetn = 1'b0;
      set_rgb(12'h467);
      cyc = 0;
      tick();
      chk("first_sample", obs(), ev(12'h467, 1'b1, 1'b1));
      set_rgb(12'h746);
      tick();
      chk("second_sample", obs(), ev(12'h746, 1'b1, 1'b1));
      set_rgb(12'hFFF);
      at(3, "hold_fff", ev(12'hFFF, 1'b1, 1'b1));

      line_checks("f1");
      at(2912,  "f1_l1_hs_pre",  ev(12'h000, 1'b1, 1'b1));
      at(2913,  "f1_l1_hs_fall", ev(12'h000, 1'b0, 1'b1));
      at(12480, "f1_l7_h639",    ev(12'hFFF, 1'b1, 1'b1));
      at(12801, "f1_l8_h0",      ev(12'h000, 1'b1, 1'b1));
      at(14080, "f1_l8_h639",    ev(12'h000, 1'b1, 1'b1));
      vsync_checks("f1");
      at(24000, "f1_last_pix",   ev(12'h000, 1'b1, 1'b1));
      chk("vblank_colour_cnt", 14'(blank_bad), 14'd0);

      at(24001, "f2_h0",         ev(12'hFFF, 1'b1, 1'b1));
      at(25312, "f2_hs_pre",     ev(12'h000, 1'b1, 1'b1));
      at(25313, "f2_hs_fall",    ev(12'h000, 1'b0, 1'b1));
      at(32400, "f2_l5_h199",    ev(12'hFFF, 1'b1, 1'b1));

      aresetn = 1'b1;
      tick();
      chk("mid_rst", obs(), ev(12'h000, 1'b1, 1'b1));
      aresetn = 1'b0;
      blank_hi = 0;
      cyc = 0;
      at(1, "r2_first", ev(12'hFFF, 1'b1, 1'b1));
      line_checks("r2");
      vsync_checks("r2");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
